// File: rtl/cache_refill_arbiter.sv
// cache_refill_arbiter
//   Shares one line-granular memory port between the icache and dcache miss paths.
//   One pending miss is picked (round-robin when both are pending). For a dcache
//   miss with a dirty victim the write-back is issued first, then the line read.
//   The fetched line goes back to the owning cache together with a 1-cycle refresh pulse.
//
// Ports
//   i_clk, i_rst                 clock, synchronous active-high reset
//   i_icache_miss/_axi_raddr     icache miss request and line address
//   o_icache_refresh/_cacheline_new  refresh pulse and returned line for icache
//   i_dcache_miss/_axi_raddr     dcache miss request and line address
//   i_dcache_write_back/_axi_waddr/_cacheline_old  dirty victim write-back info
//   o_dcache_refresh/_cacheline_new  refresh pulse and returned line for dcache
//   o_mem_req/_wr/_addr/_wdata   registered memory command
//   i_mem_gnt                    command accepted when o_mem_req & i_mem_gnt
//   i_mem_resp/i_mem_rdata       completion pulse and read line
//   o_busy                       arbiter not idle
module cache_refill_arbiter #(
  parameter int unsigned LINE_W = 128,
  parameter int unsigned ADDR_W = 32
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_icache_miss,
  input  logic [ADDR_W-1:0] i_icache_axi_raddr,
  output logic              o_icache_refresh,
  output logic [LINE_W-1:0] o_icache_cacheline_new,
  input  logic              i_dcache_miss,
  input  logic [ADDR_W-1:0] i_dcache_axi_raddr,
  input  logic              i_dcache_write_back,
  input  logic [ADDR_W-1:0] i_dcache_axi_waddr,
  input  logic [LINE_W-1:0] i_dcache_cacheline_old,
  output logic              o_dcache_refresh,
  output logic [LINE_W-1:0] o_dcache_cacheline_new,
  output logic              o_mem_req,
  output logic              o_mem_wr,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [LINE_W-1:0] o_mem_wdata,
  input  logic              i_mem_gnt,
  input  logic              i_mem_resp,
  input  logic [LINE_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  typedef enum logic [2:0] {
    StIdle, StWbCmd, StWbWait, StRdCmd, StRdWait, StDone, StGap
  } state_e;

  state_e            r_state;
  logic              r_last_dcache;   // 1: dcache was granted last
  logic              r_owner_dcache;  // 1: current transaction belongs to dcache
  logic [ADDR_W-1:0] r_raddr;
  logic              r_mem_req;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [LINE_W-1:0] r_mem_wdata;
  logic              r_icache_refresh;
  logic              r_dcache_refresh;
  logic [LINE_W-1:0] r_icache_line;
  logic [LINE_W-1:0] r_dcache_line;

  logic w_any_miss;
  logic w_grant_dcache;

  assign w_any_miss = i_icache_miss | i_dcache_miss;
  // With both pending, the cache not granted last wins.
  assign w_grant_dcache = (i_icache_miss && i_dcache_miss) ? ~r_last_dcache : i_dcache_miss;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state          <= StIdle;
      r_last_dcache    <= 1'b0;
      r_owner_dcache   <= 1'b0;
      r_raddr          <= '0;
      r_mem_req        <= 1'b0;
      r_mem_wr         <= 1'b0;
      r_mem_addr       <= '0;
      r_mem_wdata      <= '0;
      r_icache_refresh <= 1'b0;
      r_dcache_refresh <= 1'b0;
      r_icache_line    <= '0;
      r_dcache_line    <= '0;
    end else begin
      // Refresh outputs are single-cycle pulses.
      r_icache_refresh <= 1'b0;
      r_dcache_refresh <= 1'b0;
      unique case (r_state)
        StIdle: begin
          if (w_any_miss) begin
            r_owner_dcache <= w_grant_dcache;
            r_last_dcache  <= w_grant_dcache;
            r_raddr        <= w_grant_dcache ? i_dcache_axi_raddr : i_icache_axi_raddr;
            r_mem_req      <= 1'b1;
            if (w_grant_dcache && i_dcache_write_back) begin
              r_mem_wr    <= 1'b1;
              r_mem_addr  <= i_dcache_axi_waddr;
              r_mem_wdata <= i_dcache_cacheline_old;
              r_state     <= StWbCmd;
            end else begin
              r_mem_wr   <= 1'b0;
              r_mem_addr <= w_grant_dcache ? i_dcache_axi_raddr : i_icache_axi_raddr;
              r_state    <= StRdCmd;
            end
          end
        end
        StWbCmd: begin
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= StWbWait;
          end
        end
        StWbWait: begin
          if (i_mem_resp) begin
            r_mem_req  <= 1'b1;
            r_mem_wr   <= 1'b0;
            r_mem_addr <= r_raddr;
            r_state    <= StRdCmd;
          end
        end
        StRdCmd: begin
          if (i_mem_gnt) begin
            r_mem_req <= 1'b0;
            r_state   <= StRdWait;
          end
        end
        StRdWait: begin
          if (i_mem_resp) begin
            if (r_owner_dcache) begin
              r_dcache_line    <= i_mem_rdata;
              r_dcache_refresh <= 1'b1;
            end else begin
              r_icache_line    <= i_mem_rdata;
              r_icache_refresh <= 1'b1;
            end
            r_state <= StDone;
          end
        end
        StDone:  r_state <= StGap;
        // Lets the owner drop its miss before arbitration resumes.
        StGap:   r_state <= StIdle;
        default: r_state <= StIdle;
      endcase
    end
  end

  assign o_mem_req              = r_mem_req;
  assign o_mem_wr               = r_mem_wr;
  assign o_mem_addr             = r_mem_addr;
  assign o_mem_wdata            = r_mem_wdata;
  assign o_icache_refresh       = r_icache_refresh;
  assign o_dcache_refresh       = r_dcache_refresh;
  assign o_icache_cacheline_new = r_icache_line;
  assign o_dcache_cacheline_new = r_dcache_line;
  assign o_busy                 = (r_state != StIdle);

endmodule

// File: tb/tb_cache_refill_arbiter.sv
module tb_cache_refill_arbiter;
  localparam int LW = 128;
  localparam int AW = 32;

  localparam int KWr   = 0;
  localparam int KRd   = 1;
  localparam int KRefI = 2;
  localparam int KRefD = 3;

  typedef struct {
    int            kind;
    logic [AW-1:0] addr;
    logic [LW-1:0] data;
  } exp_t;

  logic          clk, rst;
  logic          icache_miss, dcache_miss, dcache_wb;
  logic [AW-1:0] icache_raddr, dcache_raddr, dcache_waddr;
  logic [LW-1:0] dcache_old;
  logic          icache_refresh, dcache_refresh;
  logic [LW-1:0] icache_line, dcache_line;
  logic          mem_req, mem_wr, mem_gnt, mem_resp, busy;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata, mem_rdata;

  // Memory responder controls
  logic          gnt_r, gnt_block, rsp_resp, resp_force, resp_hold, spur_en;
  logic [LW-1:0] rsp_data, force_data;

  assign mem_gnt   = gnt_r & ~gnt_block;
  assign mem_resp  = rsp_resp | resp_force;
  assign mem_rdata = resp_force ? force_data : rsp_data;

  exp_t          q[$];
  int            n_chk = 0;
  int            n_pass = 0;
  int            m_last = 0;          // 0: icache granted last, 1: dcache
  logic [LW-1:0] m_iline = '0;
  logic [LW-1:0] m_dline = '0;

  cache_refill_arbiter #(.LINE_W(LW), .ADDR_W(AW)) dut (
    .i_clk                  (clk),
    .i_rst                  (rst),
    .i_icache_miss          (icache_miss),
    .i_icache_axi_raddr     (icache_raddr),
    .o_icache_refresh       (icache_refresh),
    .o_icache_cacheline_new (icache_line),
    .i_dcache_miss          (dcache_miss),
    .i_dcache_axi_raddr     (dcache_raddr),
    .i_dcache_write_back    (dcache_wb),
    .i_dcache_axi_waddr     (dcache_waddr),
    .i_dcache_cacheline_old (dcache_old),
    .o_dcache_refresh       (dcache_refresh),
    .o_dcache_cacheline_new (dcache_line),
    .o_mem_req              (mem_req),
    .o_mem_wr               (mem_wr),
    .o_mem_addr             (mem_addr),
    .o_mem_wdata            (mem_wdata),
    .i_mem_gnt              (mem_gnt),
    .i_mem_resp             (mem_resp),
    .i_mem_rdata            (mem_rdata),
    .o_busy                 (busy)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no_finish expected finish");
    $fatal(1, "watchdog");
  end

  // Memory contents: a fixed function of the line address.
  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    return {a ^ 32'hdeadbeef, ~a, a + 32'h55, {a[15:0], a[31:16]}};
  endfunction

  function automatic logic [LW-1:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [LW-1:0] act,
                     input logic [LW-1:0] exp);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Memory responder: random grant, response 0..3 cycles after acceptance.
  initial begin
    bit            acc, acc_wr, pend;
    logic [AW-1:0] acc_addr;
    logic [LW-1:0] pdata;
    int            dly;
    gnt_r = 0; rsp_resp = 0; rsp_data = '0; pend = 0; dly = 0; pdata = '0;
    forever begin
      @(negedge clk);
      acc      = mem_req && mem_gnt && !rst;
      acc_wr   = mem_wr;
      acc_addr = mem_addr;
      @(posedge clk); #1;
      rsp_resp = 0;
      if (resp_hold) pend = 0;
      else if (acc) begin
        pend  = 1;
        dly   = $urandom_range(0, 3);
        pdata = acc_wr ? rand_line() : mem_line(acc_addr);
      end
      if (pend) begin
        if (dly == 0) begin
          rsp_resp = 1; rsp_data = pdata; pend = 0;
        end else dly--;
      end else if (spur_en && !resp_hold && !busy && $urandom_range(0, 3) == 0) begin
        rsp_resp = 1; rsp_data = rand_line();
      end
      gnt_r = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: pops expected events whenever the DUT presents a command or refresh.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) continue;
      if (mem_req && mem_gnt) begin
        if (q.size() == 0) chk(0, "unexpected_cmd", {96'h0, mem_addr}, '0);
        else begin
          e = q.pop_front();
          chk(e.kind == (mem_wr ? KWr : KRd), "cmd_kind", mem_wr ? KWr : KRd, e.kind);
          chk(mem_addr == e.addr, "cmd_addr", mem_addr, e.addr);
          if (e.kind == KWr) chk(mem_wdata == e.data, "cmd_wdata", mem_wdata, e.data);
        end
      end
      if (icache_refresh && dcache_refresh) chk(0, "dual_refresh", 1, 0);
      else if (icache_refresh || dcache_refresh) begin
        if (q.size() == 0) chk(0, "unexpected_refresh", {126'h0, dcache_refresh,
                                                         icache_refresh}, '0);
        else begin
          e = q.pop_front();
          chk(e.kind == (icache_refresh ? KRefI : KRefD), "refresh_owner",
              icache_refresh ? KRefI : KRefD, e.kind);
          if (icache_refresh) begin
            m_iline = e.data;
            chk(icache_line == e.data, "icache_line", icache_line, e.data);
            chk(dcache_line == m_dline, "dcache_line_hold", dcache_line, m_dline);
          end else begin
            m_dline = e.data;
            chk(dcache_line == e.data, "dcache_line", dcache_line, e.data);
            chk(icache_line == m_iline, "icache_line_hold", icache_line, m_iline);
          end
        end
      end
    end
  end

  task automatic push(input int k, input logic [AW-1:0] a, input logic [LW-1:0] d);
    exp_t e;
    e.kind = k; e.addr = a; e.data = d;
    q.push_back(e);
  endtask

  task automatic wait_idle();
    int cyc = 0;
    while (busy && cyc < 50) begin
      @(posedge clk); #1; cyc++;
    end
    if (busy) chk(0, "idle_timeout", 1, 0);
  endtask

  task automatic push_d(input bit wb, input logic [AW-1:0] da, input logic [AW-1:0] wa,
                        input logic [LW-1:0] old);
    if (wb) push(KWr, wa, old);
    push(KRd, da, '0);
    push(KRefD, '0, mem_line(da));
  endtask

  // One arbitration round: raise the chosen misses together, hold each until the
  // cycle after its refresh, then drop it.
  task automatic do_round(input bit ui, input bit ud, input bit wb,
                          input logic [AW-1:0] ia, input logic [AW-1:0] da,
                          input logic [AW-1:0] wa, input logic [LW-1:0] old);
    bit first_d, i_done, d_done, i_drop, d_drop;
    int cyc;
    wait_idle();
    first_d = ud && (!ui || m_last == 0);
    if (first_d) begin
      push_d(wb, da, wa, old);
      if (ui) begin push(KRd, ia, '0); push(KRefI, '0, mem_line(ia)); end
    end else begin
      push(KRd, ia, '0); push(KRefI, '0, mem_line(ia));
      if (ud) push_d(wb, da, wa, old);
    end
    if (ui && ud) m_last = first_d ? 0 : 1;
    else          m_last = ud ? 1 : 0;
    icache_raddr = ia; dcache_raddr = da; dcache_waddr = wa; dcache_old = old;
    dcache_wb = wb; icache_miss = ui; dcache_miss = ud;
    i_done = !ui; d_done = !ud; i_drop = 0; d_drop = 0; cyc = 0;
    while (!(i_done && d_done) && cyc < 400) begin
      @(posedge clk); #1; cyc++;
      if (i_drop) begin icache_miss = 0; i_done = 1; i_drop = 0; end
      if (d_drop) begin dcache_miss = 0; d_done = 1; d_drop = 0; end
      if (icache_refresh && !i_done) i_drop = 1;
      if (dcache_refresh && !d_done) d_drop = 1;
    end
    if (!(i_done && d_done)) begin
      chk(0, "round_timeout", {126'h0, d_done, i_done}, 3);
      icache_miss = 0; dcache_miss = 0;
    end
  endtask

  function automatic logic [AW-1:0] rand_addr();
    return $urandom & 32'hFFFF_FFC0;
  endfunction

  initial begin
    int cyc;
    rst = 1; icache_miss = 0; dcache_miss = 0; dcache_wb = 0;
    icache_raddr = '0; dcache_raddr = '0; dcache_waddr = '0; dcache_old = '0;
    gnt_block = 0; resp_force = 0; force_data = '0; resp_hold = 0; spur_en = 0;
    repeat (3) @(posedge clk);
    #1;
    rst = 0;
    // Reset state
    chk(!busy, "rst_busy", busy, 0);
    chk(!mem_req && !mem_wr, "rst_req_wr", {mem_req, mem_wr}, 0);
    chk(mem_addr == '0, "rst_addr", mem_addr, 0);
    chk(mem_wdata == '0, "rst_wdata", mem_wdata, 0);
    chk(!icache_refresh && !dcache_refresh, "rst_refresh", {icache_refresh, dcache_refresh}, 0);
    chk(icache_line == '0 && dcache_line == '0, "rst_lines", icache_line | dcache_line, 0);

    // Both misses together, four times: dcache wins first each round
    for (int r = 0; r < 4; r++)
      do_round(1, 1, r[0], rand_addr(), rand_addr(), rand_addr(), rand_line());

    // Single icache read
    do_round(1, 0, 0, 32'h1000, 32'h0, 32'h0, '0);
    // dcache write-back then read
    do_round(0, 1, 1, 32'h0, 32'h3000, 32'h2040, 128'hB0B0_B1B1_B2B2_B3B3_B4B4_B5B5_B6B6_B7B7);

    // Grant withheld while a read command waits: command must hold stable
    gnt_block = 1;
    fork
      do_round(1, 0, 0, 32'h4000, 32'h0, 32'h0, '0);
      begin
        cyc = 0;
        while (!mem_req && cyc < 20) begin @(posedge clk); #1; cyc++; end
        for (int k = 0; k < 10; k++) begin
          chk(mem_req && mem_addr == 32'h4000 && !mem_wr && !icache_refresh,
              "stall_hold", {mem_req, mem_wr, icache_refresh, mem_addr}, {3'b100, 32'h4000});
          @(posedge clk); #1;
        end
        gnt_block = 0;
      end
    join

    // Reset while waiting for read data: transaction dropped, late response ignored
    resp_hold = 1;
    wait_idle();
    push(KRd, 32'h5000, '0);
    icache_raddr = 32'h5000; icache_miss = 1;
    cyc = 0;
    while (q.size() > 0 && cyc < 50) begin @(posedge clk); #1; cyc++; end
    rst = 1;
    @(posedge clk); #1;
    rst = 0; icache_miss = 0;
    m_last = 0; m_iline = '0; m_dline = '0;
    chk(!busy && !mem_req, "midrst_idle", {busy, mem_req}, 0);
    chk(icache_line == '0 && dcache_line == '0, "midrst_lines", icache_line | dcache_line, 0);
    force_data = rand_line(); resp_force = 1;
    @(posedge clk); #1;
    resp_force = 0;
    for (int k = 0; k < 4; k++) begin
      chk(!icache_refresh && !dcache_refresh && !busy && !mem_req, "late_resp_ignored",
          {icache_refresh, dcache_refresh, busy, mem_req}, 0);
      @(posedge clk); #1;
    end
    resp_hold = 0;

    // Randomized rounds with spurious responses while idle
    spur_en = 1;
    for (int r = 0; r < 40; r++) begin
      int sel;
      sel = $urandom_range(1, 3);
      do_round(sel[0], sel[1], $urandom_range(0, 1) == 1, rand_addr(), rand_addr(),
               rand_addr(), rand_line());
    end
    spur_en = 0;

    repeat (5) @(posedge clk);
    #1;
    chk(q.size() == 0, "queue_drained", q.size(), 0);
    chk(!busy, "final_idle", busy, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
